// File: rtl/mac_pkg.sv
// Shared types and helpers for the time-multiplexed MAC engine: FSM state
// encoding, output saturation and configuration sanity check.
package mac_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // Widest accumulator the saturation helper can handle.
   localparam int SatW = 128;

   typedef struct packed {
      logic signed [SatW-1:0] value;
      logic                   flag;
   } sat_t;

   // Clip a sign-extended accumulator to an out_w-bit signed range.
   function automatic sat_t saturate(input logic signed [SatW-1:0] acc, input int out_w);
      sat_t                   res;
      logic signed [SatW-1:0] max_v;
      logic signed [SatW-1:0] min_v;
      for (int i = 0; i < SatW; i++) begin
         max_v[i] = (i < out_w - 1) ? 1'b1 : 1'b0;
      end
      min_v = ~max_v;
      if (acc > max_v) begin
         res.value = max_v;
         res.flag  = 1'b1;
      end else if (acc < min_v) begin
         res.value = min_v;
         res.flag  = 1'b1;
      end else begin
         res.value = acc;
         res.flag  = 1'b0;
      end
      return res;
   endfunction

   function automatic bit cfg_ok(input int area, input int lanes, input int acc_w, input int out_w);
      return (lanes > 0) && ((area % lanes) == 0) && (acc_w >= out_w) && (acc_w <= SatW);
   endfunction

endpackage

// File: rtl/mac_lane_sum.sv
// Combinational sum of Lanes pixel*weight products, each sign-extended to
// AccWidth; the sum wraps modulo 2^AccWidth.
module mac_lane_sum #(
   parameter int WidthIn     = 1,
   parameter int WeightWidth = 2,
   parameter int AccWidth    = 40,
   parameter int Lanes       = 3,
   parameter int SignedIn    = 0
) (
   input  logic [Lanes*WidthIn-1:0]     i_pix,
   input  logic [Lanes*WeightWidth-1:0] i_wgt,
   output logic signed [AccWidth-1:0]   o_sum
);

   logic signed [AccWidth-1:0] w_prod [Lanes];

   for (genvar g = 0; g < Lanes; g++) begin : g_lane
      logic signed [WidthIn:0]       w_px;
      logic signed [WeightWidth-1:0] w_wt;
      // Unsigned pixels get a zero MSB so the product stays signed.
      assign w_px = (SignedIn != 0) ?
                    {i_pix[g*WidthIn+WidthIn-1], i_pix[g*WidthIn +: WidthIn]} :
                    {1'b0, i_pix[g*WidthIn +: WidthIn]};
      assign w_wt      = i_wgt[g*WeightWidth +: WeightWidth];
      assign w_prod[g] = AccWidth'(w_px) * AccWidth'(w_wt);
   end

   always_comb begin
      o_sum = '0;
      for (int i = 0; i < Lanes; i++) begin
         o_sum = o_sum + w_prod[i];
      end
   end

endmodule

// File: rtl/mac_seq.sv
// Sequential multiply-accumulate engine: one window per input channel over
// valid/ready, Lanes taps per cycle, saturated result under valid/ready.
module mac_seq
   import mac_pkg::*;
#(
   parameter int KernelWidth = 3,
   parameter int WidthIn     = 1,
   parameter int WeightWidth = 2,
   parameter int WidthOut    = 32,
   parameter int AccWidth    = 40,
   parameter int Lanes       = 3,
   parameter int InChannels  = 1,
   parameter int SignedIn    = 0
) (
   input  logic                                            clk_i,
   input  logic                                            rst_i,
   input  logic                                            valid_i,
   output logic                                            ready_o,
   input  logic [KernelWidth*KernelWidth*WidthIn-1:0]      window_i,
   input  logic [KernelWidth*KernelWidth*WeightWidth-1:0]  weights_i,
   input  logic signed [WidthOut-1:0]                      bias_i,
   output logic                                            valid_o,
   input  logic                                            ready_i,
   output logic signed [WidthOut-1:0]                      data_o,
   output logic                                            sat_o
);

   localparam int KernelArea = KernelWidth * KernelWidth;
   localparam int Steps      = KernelArea / Lanes;
   localparam int StepW      = (Steps > 1) ? $clog2(Steps) : 1;
   localparam int ChanW      = (InChannels > 1) ? $clog2(InChannels) : 1;
   localparam int LaneW      = Lanes * WidthIn;
   localparam int LaneG      = Lanes * WeightWidth;

   if (!cfg_ok(KernelArea, Lanes, AccWidth, WidthOut)) begin : g_cfg_err
      $error("mac_seq: Lanes must divide KernelArea and AccWidth must cover WidthOut");
   end

   state_t                          r_state;
   state_t                          w_state_nxt;
   logic [StepW-1:0]                r_step;
   logic [ChanW-1:0]                r_chan;
   logic signed [AccWidth-1:0]      r_acc;
   logic [KernelArea*WidthIn-1:0]   r_win;
   logic [KernelArea*WeightWidth-1:0] r_wgt;
   logic                            r_ready;
   logic                            r_valid;
   logic signed [WidthOut-1:0]      r_data;
   logic                            r_sat;
   logic signed [AccWidth-1:0]      w_lane_sum;
   logic signed [AccWidth-1:0]      w_acc_nxt;
   sat_t                            w_sat;
   logic                            w_last_step;
   logic                            w_last_chan;

   assign w_last_step = (r_step == StepW'(Steps - 1));
   assign w_last_chan = (r_chan == ChanW'(InChannels - 1));

   mac_lane_sum #(
      .WidthIn     (WidthIn),
      .WeightWidth (WeightWidth),
      .AccWidth    (AccWidth),
      .Lanes       (Lanes),
      .SignedIn    (SignedIn)
   ) u_lane_sum (
      .i_pix (r_win[r_step*LaneW +: LaneW]),
      .i_wgt (r_wgt[r_step*LaneG +: LaneG]),
      .o_sum (w_lane_sum)
   );

   assign w_acc_nxt = r_acc + w_lane_sum;
   assign w_sat     = saturate(SatW'(w_acc_nxt), WidthOut);

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (valid_i) w_state_nxt = BUSY;
            else         w_state_nxt = IDLE;
         end
         BUSY: begin
            if (!w_last_step)     w_state_nxt = BUSY;
            else if (w_last_chan) w_state_nxt = DONE;
            else                  w_state_nxt = IDLE;
         end
         DONE: begin
            if (ready_i) w_state_nxt = IDLE;
            else         w_state_nxt = DONE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   // Datapath: capture, accumulate, and register the saturated result.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_step  <= '0;
         r_chan  <= '0;
         r_acc   <= '0;
         r_win   <= '0;
         r_wgt   <= '0;
         r_ready <= 1'b1;
         r_valid <= 1'b0;
         r_data  <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_ready <= (w_state_nxt == IDLE);
         case (r_state)
            IDLE: begin
               if (valid_i) begin
                  r_win  <= window_i;
                  r_wgt  <= weights_i;
                  r_step <= '0;
                  if (r_chan == '0) r_acc <= AccWidth'(bias_i);
               end
            end
            BUSY: begin
               r_acc <= w_acc_nxt;
               if (w_last_step) begin
                  r_step <= '0;
                  if (w_last_chan) begin
                     r_data  <= w_sat.value[WidthOut-1:0];
                     r_sat   <= w_sat.flag;
                     r_valid <= 1'b1;
                  end else begin
                     r_chan <= r_chan + 1'b1;
                  end
               end else begin
                  r_step <= r_step + 1'b1;
               end
            end
            DONE: begin
               if (ready_i) begin
                  r_valid <= 1'b0;
                  r_chan  <= '0;
               end
            end
            default: begin
               r_step <= '0;
               r_chan <= '0;
            end
         endcase
      end
   end

   assign ready_o = r_ready;
   assign valid_o = r_valid;
   assign data_o  = r_data;
   assign sat_o   = r_sat;

endmodule

// File: tb/tb_mac_seq.sv
// Directed scoreboard bench for mac_seq: default build, a two-channel build
// and a wide saturating build share one clock and reset.
module tb_mac_seq;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        vld  [3];
   logic        ri   [3];
   logic [71:0] win  [3];
   logic [71:0] wgt  [3];
   logic [31:0] bias [3];

   logic        rdy  [3];
   logic        vo   [3];
   logic        sto  [3];
   logic [31:0] dout [3];

   logic        rdy0, rdy1, rdy2, vo0, vo1, vo2, s0, s1, s2;
   logic [31:0] d0, d1;
   logic [7:0]  d2;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int     k;
      longint data;
      bit     sat;
   } exp_t;
   exp_t sb[$];

   mac_seq u_dut0 (
      .clk_i(clk), .rst_i(rst), .valid_i(vld[0]), .ready_o(rdy0),
      .window_i(win[0][8:0]), .weights_i(wgt[0][17:0]), .bias_i(bias[0]),
      .valid_o(vo0), .ready_i(ri[0]), .data_o(d0), .sat_o(s0)
   );

   mac_seq #(.InChannels(2)) u_dut1 (
      .clk_i(clk), .rst_i(rst), .valid_i(vld[1]), .ready_o(rdy1),
      .window_i(win[1][8:0]), .weights_i(wgt[1][17:0]), .bias_i(bias[1]),
      .valid_o(vo1), .ready_i(ri[1]), .data_o(d1), .sat_o(s1)
   );

   mac_seq #(.WidthIn(8), .WeightWidth(8), .WidthOut(8)) u_dut2 (
      .clk_i(clk), .rst_i(rst), .valid_i(vld[2]), .ready_o(rdy2),
      .window_i(win[2]), .weights_i(wgt[2]), .bias_i(bias[2][7:0]),
      .valid_o(vo2), .ready_i(ri[2]), .data_o(d2), .sat_o(s2)
   );

   always_comb begin
      rdy[0] = rdy0; rdy[1] = rdy1; rdy[2] = rdy2;
      vo[0]  = vo0;  vo[1]  = vo1;  vo[2]  = vo2;
      sto[0] = s0;   sto[1] = s1;   sto[2] = s2;
      dout[0] = d0;  dout[1] = d1;  dout[2] = {{24{d2[7]}}, d2};
   end

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Nine copies of an ww-bit field.
   function automatic logic [71:0] rep(input int ww, input logic [7:0] val);
      logic [71:0] r;
      r = '0;
      for (int t = 0; t < 9; t++)
         for (int b = 0; b < ww; b++)
            r[t*ww+b] = val[b];
      return r;
   endfunction

   // Reference sum of products: unsigned pixels, signed weights.
   function automatic longint sop(input logic [71:0] w, input logic [71:0] g, input int wi, input int ww);
      longint s, p, q;
      s = 0;
      for (int t = 0; t < 9; t++) begin
         p = 0;
         q = 0;
         for (int b = 0; b < wi; b++) p += longint'(w[t*wi+b]) << b;
         for (int b = 0; b < ww; b++) q += longint'(g[t*ww+b]) << b;
         if (q >= (longint'(1) << (ww - 1))) q -= longint'(1) << ww;
         s += p * q;
      end
      return s;
   endfunction

   function automatic void push_exp(input int k, input longint acc, input int wo);
      exp_t   e;
      longint mx, mn;
      mx = (longint'(1) << (wo - 1)) - 1;
      mn = -mx - 1;
      e.k = k;
      if (acc > mx)      begin e.data = mx;  e.sat = 1'b1; end
      else if (acc < mn) begin e.data = mn;  e.sat = 1'b1; end
      else               begin e.data = acc; e.sat = 1'b0; end
      sb.push_back(e);
   endfunction

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send(input int k, input logic [71:0] w, input logic [71:0] g, input logic [31:0] b);
      int n;
      n = 0;
      while (!rdy[k] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("send_ready", rdy[k], 1);
      win[k]  = w;
      wgt[k]  = g;
      bias[k] = b;
      vld[k]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      vld[k]  = 1'b0;
   endtask

   task automatic recv(input int k, input int lat, input int hold);
      int   n;
      exp_t e;
      n = 0;
      while (!vo[k] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, lat);
      chk("sb_size", sb.size(), 1);
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{k: k, data: 0, sat: 1'b0};
      chk("sb_dut", k, e.k);
      chk("data", $signed(dout[k]), e.data);
      chk("sat", sto[k], e.sat);
      for (int i = 0; i < hold; i++) begin
         if (i % 2 == 1) begin
            vld[k] = 1'b1;
            win[k] = {$urandom(), $urandom(), $urandom()};
         end else begin
            vld[k] = 1'b0;
         end
         @(negedge clk);
         chk("hold_valid", vo[k], 1);
         chk("hold_data", $signed(dout[k]), e.data);
         chk("hold_sat", sto[k], e.sat);
         chk("hold_ready", rdy[k], 0);
      end
      vld[k] = 1'b0;
      ri[k]  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      ri[k]  = 1'b0;
      chk("consumed", vo[k], 0);
      chk("ready_back", rdy[k], 1);
   endtask

   initial begin
      logic [71:0] rw, rg;
      int          rb;

      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         vld[k] = 1'b0; ri[k] = 1'b0; win[k] = '0; wgt[k] = '0; bias[k] = '0;
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_ready", rdy[0], 1);
      chk("rst_valid", vo[0], 0);
      chk("rst_data", dout[0], 0);
      chk("rst_sat", sto[0], 0);
      chk("rst_valid2", vo[2], 0);
      @(negedge clk);

      // All-ones window, +1 weights, zero bias.
      push_exp(0, sop(rep(1, 8'h01), rep(2, 8'h01), 1, 2), 32);
      send(0, rep(1, 8'h01), rep(2, 8'h01), 32'd0);
      recv(0, 3, 0);

      // -2 weights with bias 5.
      push_exp(0, sop(rep(1, 8'h01), rep(2, 8'h02), 1, 2) + 5, 32);
      send(0, rep(1, 8'h01), rep(2, 8'h02), 32'd5);
      recv(0, 3, 0);

      // Reset while BUSY at step 1 discards everything.
      send(0, rep(1, 8'h01), rep(2, 8'h01), 32'd77);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst_valid", vo[0], 0);
      chk("midrst_data", dout[0], 0);
      chk("midrst_sat", sto[0], 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_ready", rdy[0], 1);
      @(negedge clk);
      push_exp(0, sop(rep(1, 8'h01), rep(2, 8'h01), 1, 2), 32);
      send(0, rep(1, 8'h01), rep(2, 8'h01), 32'd0);
      recv(0, 3, 0);

      // Random window held in DONE for 10 stalled cycles.
      rw = 72'($urandom_range(0, 511));
      rg = 72'($urandom_range(0, 262143));
      rb = int'($urandom_range(0, 2000)) - 1000;
      push_exp(0, sop(rw, rg, 1, 2) + longint'(rb), 32);
      send(0, rw, rg, rb);
      recv(0, 3, 10);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("no_extra", vo[0], 0);
      end

      // Two channels: bias taken only from the first accept.
      push_exp(1, 4 + 2 * sop(rep(1, 8'h01), rep(2, 8'h01), 1, 2), 32);
      send(1, rep(1, 8'h01), rep(2, 8'h01), 32'd4);
      chk("ch0_busy0", rdy[1], 0);
      @(negedge clk);
      chk("ch0_busy1", rdy[1], 0);
      @(negedge clk);
      chk("ch0_busy2", rdy[1], 0);
      @(negedge clk);
      chk("ch0_ready", rdy[1], 1);
      chk("ch0_novalid", vo[1], 0);
      send(1, rep(1, 8'h01), rep(2, 8'h01), 32'd100);
      chk("ch1_busy0", rdy[1], 0);
      @(negedge clk);
      chk("ch1_busy1", rdy[1], 0);
      @(negedge clk);
      chk("ch1_busy2", rdy[1], 0);
      recv(1, 1, 0);

      // Wide build: positive and negative saturation.
      push_exp(2, sop(rep(8, 8'hFF), rep(8, 8'h7F), 8, 8), 8);
      send(2, rep(8, 8'hFF), rep(8, 8'h7F), 32'd0);
      recv(2, 3, 0);
      push_exp(2, sop(rep(8, 8'hFF), rep(8, 8'h80), 8, 8), 8);
      send(2, rep(8, 8'hFF), rep(8, 8'h80), 32'd0);
      recv(2, 3, 0);

      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

endmodule
